seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Six-digit multiplexed 7-segment scan controller with per-frame
//            snapshot, blanking gap and optional digit blink
//            (blink enabled by defining SEG_SCAN_BLINK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int unsigned CLK_DIV      = 1000,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] time_bcd,
    input  logic [5:0]  blink_mask,
    input  logic        dp_en,
    output logic [3:0]  digit_bcd,
    input  logic [7:0]  seg_data_in,
    output logic [7:0]  seg_out,
    output logic [5:0]  seg_com,
    output logic        frame_sync
);

    localparam logic [0:0]  c_st_blank   = 1'b0;
    localparam logic [0:0]  c_st_drive   = 1'b1;
    localparam logic [15:0] c_drive_last = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_blank_last = 16'(BLANK_CYC - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic        r_start;
    logic [23:0] r_snap_time;
    logic [3:0]  r_digit;
    logic        r_frame_sync;
    logic [5:0]  r_seg_com;
    logic        r_drive_en;
    logic        r_dp_on;
    logic        w_blank_done;
    logic        w_drive_done;
    logic        w_wrap;
    logic        w_frame_load;
    logic        w_blink_hide;
    logic [5:0]  w_seg_com_nxt;
    logic        w_drive_en_nxt;
    logic        w_dp_on_nxt;

    function automatic logic [3:0] f_nibble(input logic [23:0] v, input logic [2:0] i);
        case (i)
            3'd0:    return v[3:0];
            3'd1:    return v[7:4];
            3'd2:    return v[11:8];
            3'd3:    return v[15:12];
            3'd4:    return v[19:16];
            default: return v[23:20];
        endcase
    endfunction

    assign w_blank_done = (r_state == c_st_blank) && (r_cnt == c_blank_last);
    assign w_drive_done = (r_state == c_st_drive) && (r_cnt == c_drive_last);
    assign w_wrap       = w_drive_done && (r_idx == 3'd5);
    // The first edge after reset release opens a frame just like a wrap does.
    assign w_frame_load = r_start || w_wrap;
    assign w_idx_nxt    = w_wrap ? 3'd0 : r_idx + 3'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_blank;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (r_start) begin
            w_state_nxt = c_st_blank;
        end else if (w_blank_done) begin
            w_state_nxt = c_st_drive;
        end else if (w_drive_done) begin
            w_state_nxt = c_st_blank;
        end
    end

    // Output decode; r_idx only moves on DRIVE->BLANK, so it is already the
    // slot being entered whenever the next state is DRIVE.
    always_comb begin
        w_seg_com_nxt  = 6'b111111;
        w_drive_en_nxt = 1'b0;
        w_dp_on_nxt    = 1'b0;
        if (w_state_nxt == c_st_drive) begin
            w_seg_com_nxt  = ~(6'b000001 << r_idx);
            w_drive_en_nxt = ~w_blink_hide;
            w_dp_on_nxt    = dp_en && ((r_idx == 3'd2) || (r_idx == 3'd4));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_start      <= 1'b1;
            r_snap_time  <= '0;
            r_digit      <= '0;
            r_frame_sync <= 1'b0;
            r_seg_com    <= 6'b111111;
            r_drive_en   <= 1'b0;
            r_dp_on      <= 1'b0;
        end else begin
            r_start      <= 1'b0;
            r_frame_sync <= w_frame_load;
            r_seg_com    <= w_seg_com_nxt;
            r_drive_en   <= w_drive_en_nxt;
            r_dp_on      <= w_dp_on_nxt;
            if (r_start || w_blank_done || w_drive_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_drive_done) begin
                r_idx <= w_idx_nxt;
            end
            // Digit 0 of a new frame comes straight from the input being captured.
            if (w_frame_load) begin
                r_snap_time <= time_bcd;
                r_digit     <= time_bcd[3:0];
            end else if (w_drive_done) begin
                r_digit <= f_nibble(r_snap_time, w_idx_nxt);
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam logic [7:0] c_blink_last = 8'(BLINK_FRAMES - 1);

    logic [5:0] r_snap_mask;
    logic [7:0] r_frame_cnt;
    logic       r_blink_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_mask <= '0;
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            if (w_frame_load) begin
                r_snap_mask <= blink_mask;
            end
            if (w_wrap) begin
                if (r_frame_cnt == c_blink_last) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    assign w_blink_hide = ~r_blink_on & r_snap_mask[r_idx];
`else
    logic w_unused_blink;
    assign w_unused_blink = ^{blink_mask, 8'(BLINK_FRAMES)};
    assign w_blink_hide   = 1'b0;
`endif

    assign digit_bcd  = r_digit;
    assign seg_com    = r_seg_com;
    assign frame_sync = r_frame_sync;
    assign seg_out    = r_drive_en ? {seg_data_in[7:1], seg_data_in[0] | r_dp_on} : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl (CLK_DIV=4, BLANK_CYC=2,
//            BLINK_FRAMES=2; frame = 36 cycles, slot = 2 blank + 4 drive).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_frame = 36;

    typedef struct {
        logic [23:0] time_bcd;
        logic [5:0]  blink_mask;
        logic        dp_en;
        logic [7:0]  seg_data_in;
        logic [5:0]  exp_dp_slots;
        logic [5:0]  exp_dark;
    } vec_t;

`ifdef SEG_SCAN_BLINK_EN
    localparam logic [5:0] c_dark = 6'b000011;
`else
    localparam logic [5:0] c_dark = 6'b000000;
`endif

    logic        clk;
    logic        rst_n;
    logic [23:0] time_bcd;
    logic [5:0]  blink_mask;
    logic        dp_en;
    logic [3:0]  digit_bcd;
    logic [7:0]  seg_data_in;
    logic [7:0]  seg_out;
    logic [5:0]  seg_com;
    logic        frame_sync;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs [8];
    vec_t tear_row;
    vec_t tear_next;
    vec_t rst_row;
    vec_t post_row;

    seg_scan_ctrl #(
        .CLK_DIV      (4),
        .BLANK_CYC    (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .time_bcd    (time_bcd),
        .blink_mask  (blink_mask),
        .dp_en       (dp_en),
        .digit_bcd   (digit_bcd),
        .seg_data_in (seg_data_in),
        .seg_out     (seg_out),
        .seg_com     (seg_com),
        .frame_sync  (frame_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input vec_t v);
        time_bcd    = v.time_bcd;
        blink_mask  = v.blink_mask;
        dp_en       = v.dp_en;
        seg_data_in = v.seg_data_in;
    endtask

    task automatic compare(input string tag, input int pos, input logic [5:0] e_com,
                           input logic [7:0] e_seg, input logic [3:0] e_dig, input logic e_fs);
        n_vec++;
        if (seg_com !== e_com || seg_out !== e_seg || digit_bcd !== e_dig || frame_sync !== e_fs) begin
            n_err++;
            $display("FAIL %s pos=%0d: got com=%b seg=%h dig=%h fs=%b, want com=%b seg=%h dig=%h fs=%b",
                     tag, pos, seg_com, seg_out, digit_bcd, frame_sync, e_com, e_seg, e_dig, e_fs);
        end
    endtask

    // Expected outputs at a given position inside a frame whose snapshot is v.
    task automatic check_cycle(input string tag, input int pos, input vec_t v);
        int          slot;
        logic        blank;
        logic [5:0]  e_com;
        logic [7:0]  e_seg;
        logic [3:0]  e_dig;
        slot  = pos / 6;
        blank = (pos % 6) < 2;
        e_dig = 4'(v.time_bcd >> (4 * slot));
        e_com = blank ? 6'b111111 : ~(6'b000001 << slot);
        if (blank || v.exp_dark[slot])
            e_seg = 8'h00;
        else
            e_seg = {v.seg_data_in[7:1], v.seg_data_in[0] | v.exp_dp_slots[slot]};
        compare(tag, pos, e_com, e_seg, e_dig, pos == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{24'h123456, 6'b000011, 1'b0, 8'hFC, 6'b000000, 6'b000000};
        vecs[1] = '{24'h123456, 6'b000011, 1'b1, 8'hFC, 6'b010100, 6'b000000};
        vecs[2] = '{24'h000000, 6'b000011, 1'b0, 8'h60, 6'b000000, c_dark};
        vecs[3] = '{24'h987654, 6'b000011, 1'b1, 8'h01, 6'b010100, c_dark};
        vecs[4] = '{24'h090959, 6'b000011, 1'b0, 8'hB6, 6'b000000, 6'b000000};
        vecs[5] = '{24'h235959, 6'b000011, 1'b1, 8'h00, 6'b010100, 6'b000000};
        vecs[6] = '{24'h111111, 6'b000011, 1'b0, 8'hFE, 6'b000000, c_dark};
        vecs[7] = '{24'h000000, 6'b000011, 1'b1, 8'h80, 6'b010100, c_dark};
        tear_row  = '{24'h123456, 6'b000000, 1'b0, 8'hFC, 6'b000000, 6'b000000};
        tear_next = '{24'h000000, 6'b000000, 1'b0, 8'hFC, 6'b000000, 6'b000000};
        rst_row   = '{24'h777777, 6'b000000, 1'b0, 8'hFF, 6'b000000, 6'b000000};
        post_row  = '{24'h654321, 6'b000000, 1'b0, 8'hFC, 6'b000000, 6'b000000};

        rst_n = 1'b0;
        apply(vecs[0]);
        repeat (3) begin
            @(negedge clk);
            compare("reset_hold", 0, 6'b111111, 8'h00, 4'h0, 1'b0);
        end
        rst_n = 1'b1;

        // Eight consecutive frames from reset; inputs for the next frame are
        // presented in the last cycle of the current one.
        for (int f = 0; f < 8; f++) begin
            for (int p = 0; p < c_frame; p++) begin
                @(negedge clk);
                check_cycle("table", p, vecs[f]);
                if (p == c_frame - 1) apply(f < 7 ? vecs[f + 1] : tear_row);
            end
        end

        // time_bcd changes during DRIVE of idx 2; the frame keeps its snapshot.
        for (int p = 0; p < c_frame; p++) begin
            @(negedge clk);
            check_cycle("tear_hold", p, tear_row);
            if (p == 14) time_bcd = 24'h000000;
            if (p == c_frame - 1) apply(tear_next);
        end
        for (int p = 0; p < c_frame; p++) begin
            @(negedge clk);
            check_cycle("tear_next", p, tear_next);
            if (p == c_frame - 1) apply(rst_row);
        end

        // Reset asserted during DRIVE of idx 3 clears outputs without a clock edge.
        for (int p = 0; p < 22; p++) begin
            @(negedge clk);
            check_cycle("pre_reset", p, rst_row);
        end
        rst_n = 1'b0;
        #1;
        compare("async_reset", 21, 6'b111111, 8'h00, 4'h0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            compare("reset_hold2", 0, 6'b111111, 8'h00, 4'h0, 1'b0);
        end
        apply(post_row);
        rst_n = 1'b1;
        for (int p = 0; p <= c_frame; p++) begin
            @(negedge clk);
            check_cycle("restart", p % c_frame, post_row);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
